mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl_pkg.sv | 28 ++
 rtl/mult_bit_counter.sv | 41 ++++
 rtl/mult_ctrl.sv | 84 ++++++++
 tb/tb_mult_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// ============================================================================
//  Module      : mult_ctrl_pkg
//  Description : Shared shift-add multiplier types: FSM state encoding,
//                default operand width and the counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_ctrl_pkg;

    localparam int MULT_N = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } mult_state_t;

    // A one-bit multiplier still needs a one-bit index bus.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_bit_counter.sv
// ============================================================================
//  Module      : mult_bit_counter
//  Description : Multiplier bit-index counter with clear, enable and a
//                terminal-count flag at N-1; saturates rather than wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_bit_counter
    import mult_ctrl_pkg::*;
#(
    parameter int N = MULT_N
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    output logic [cnt_width(N)-1:0] o_count,
    output logic                    o_tc
);

    localparam int                CW     = cnt_width(N);
    localparam logic [CW-1:0]     c_LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mult_ctrl.sv
// ============================================================================
//  Module      : mult_ctrl
//  Description : Add/shift multiplier controller driving an external
//                accumulator with combinational Load/Ad/Sh strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N = MULT_N
)
(
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    St,
    input  logic                    M,
    output logic                    Load,
    output logic                    Ad,
    output logic                    Sh,
    output logic                    Busy,
    output logic                    Done,
    output logic [cnt_width(N)-1:0] Count
);

    mult_state_t r_state;
    logic        w_clr;
    logic        w_en;
    logic        w_tc;

    // Clearing on the start edge makes Count read 0 already in LOAD.
    assign w_clr = ((r_state == S_IDLE) && St) || (r_state == S_LOAD);
    assign w_en  = (r_state == S_SHIFT) && !w_tc;

    mult_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk     (Clk),
        .rst     (Rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (Count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (St) r_state <= S_LOAD;
                S_LOAD:  r_state <= S_TEST;
                S_TEST:  r_state <= S_SHIFT;
                S_SHIFT: r_state <= w_tc ? S_DONE : S_TEST;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are forced low while reset is asserted so the accumulator
    // never acts on a state that is about to be discarded.
    always_comb begin
        Load = 1'b0;
        Ad   = 1'b0;
        Sh   = 1'b0;
        Busy = 1'b0;
        Done = 1'b0;
        if (!Rst) begin
            Busy = (r_state != S_IDLE);
            case (r_state)
                S_LOAD:  Load = 1'b1;
                S_TEST:  Ad   = M;
                S_SHIFT: Sh   = 1'b1;
                S_DONE:  Done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
// ============================================================================
//  Module      : tb_mult_ctrl
//  Description : Self-checking bench: controller plus accumulator, product
//                and pulse counts compared against arithmetic expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_ctrl;

    localparam int N  = 32;
    localparam int CW = $clog2(N);

    logic          Clk = 1'b0;
    logic          Rst, St, M;
    logic          Load, Ad, Sh, Busy, Done;
    logic [CW-1:0] Count;

    logic [2*N:0]  acc;
    logic [N-1:0]  mcand, mplier;
    logic          use_rand_m, rand_m;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0;
    int n_load, n_ad, n_sh, n_done, n_excl, n_adsh, n_cntbad, max_cnt;
    logic prev_ad;

    always #5 Clk = ~Clk;

    mult_ctrl #(.N(N)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .St    (St),
        .M     (M),
        .Load  (Load),
        .Ad    (Ad),
        .Sh    (Sh),
        .Busy  (Busy),
        .Done  (Done),
        .Count (Count)
    );

    // Classic shift-add accumulator: upper half gets the adds, whole
    // register shifts right, multiplier LSB feeds back as M.
    always @(posedge Clk) begin
        if (Load)
            acc <= {{(N+1){1'b0}}, mplier};
        else if (Ad)
            acc[2*N:N] <= acc[2*N:N] + {1'b0, mcand};
        else if (Sh)
            acc <= acc >> 1;
    end

    assign M = use_rand_m ? rand_m : acc[0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_load = 0; n_ad = 0; n_sh = 0; n_done = 0;
        n_excl = 0; n_adsh = 0; n_cntbad = 0; max_cnt = 0;
        prev_ad = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (int'(Load) + int'(Ad) + int'(Sh) > 1) n_excl++;
        if (prev_ad && !Sh) n_adsh++;
        if (Sh && (int'(Count) != n_sh)) n_cntbad++;
        if (int'(Count) > max_cnt) max_cnt = int'(Count);
        prev_ad = Ad;
        n_load += int'(Load);
        n_ad   += int'(Ad);
        n_sh   += int'(Sh);
        n_done += int'(Done);
    endtask

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        mcand  = a;
        mplier = b;
        clear_counts();
        St = 1'b1;
        step();
        c0 = cyc;
        chk("load_first", {30'd0, Load, Busy}, 64'd3);
        chk("cnt_load", 64'(Count), 64'd0);
    endtask

    // mode 0: St low during busy, 1: random St during busy, 2: St held high
    task automatic finish_op(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
        int k;
        k = 0;
        while (!Done && k < 4*N) begin
            if (mode == 1) St = 1'($urandom_range(0, 1));
            else if (mode == 0) St = 1'b0;
            step();
            k++;
        end
        chk("done_seen", 64'(Done), 64'd1);
        chk("latency", 64'(cyc - c0), 64'(2*N + 1));
        chk("cnt_done", 64'(Count), 64'(N - 1));
        chk("product", acc[2*N-1:0], 64'(a) * 64'(b));
        if (mode != 2) St = 1'b0;
        step();
        chk("done_pulse", {62'd0, Done, Busy}, 64'd0);
        chk("n_load", 64'(n_load), 64'd1);
        chk("n_ad", 64'(n_ad), 64'($countones(b)));
        chk("n_sh", 64'(n_sh), 64'(N));
        chk("n_done", 64'(n_done), 64'd1);
        chk("exclusive", 64'(n_excl), 64'd0);
        chk("ad_then_sh", 64'(n_adsh), 64'd0);
        chk("cnt_index", 64'(n_cntbad), 64'd0);
        chk("cnt_max", 64'(max_cnt <= N - 1), 64'd1);
    endtask

    initial begin
        logic [N-1:0] a, b;
        int k;
        Rst = 1'b1; St = 1'b0; use_rand_m = 1'b0; rand_m = 1'b0;
        mcand = '0; mplier = '0; acc = '0;
        clear_counts();

        repeat (3) step();
        chk("rst_outs", {59'd0, Load, Ad, Sh, Busy, Done}, 64'd0);
        chk("rst_count", 64'(Count), 64'd0);
        St = 1'b1;
        step();
        chk("rst_prio", {62'd0, Busy, Load}, 64'd0);
        Rst = 1'b0; St = 1'b0;

        // M wiggling while idle must not disturb anything
        use_rand_m = 1'b1;
        repeat (4) begin
            rand_m = 1'($urandom);
            step();
            chk("idle_m", {59'd0, Load, Ad, Sh, Busy, Done}, 64'd0);
        end
        use_rand_m = 1'b0;
        step();

        start_op(32'd7, 32'd5);
        finish_op(32'd7, 32'd5, 0);

        start_op(32'd9, 32'd0);
        finish_op(32'd9, 32'd0, 0);

        start_op(32'd1, 32'hFFFF_FFFF);
        finish_op(32'd1, 32'hFFFF_FFFF, 0);

        // Abort in the TEST cycle that processes bit 10
        start_op(32'($urandom), 32'($urandom));
        St = 1'b0;
        k = 0;
        while (!(int'(Count) == 10 && Busy && !Load && !Sh && !Done) && k < 4*N) begin
            step();
            k++;
        end
        chk("found_test10", 64'(k < 4*N), 64'd1);
        Rst = 1'b1;
        step();
        chk("abort_outs", {59'd0, Load, Ad, Sh, Busy, Done}, 64'd0);
        chk("abort_count", 64'(Count), 64'd0);
        Rst = 1'b0;
        clear_counts();
        repeat (8) step();
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_quiet", 64'(n_load + n_sh), 64'd0);
        start_op(32'd123, 32'd456);
        finish_op(32'd123, 32'd456, 0);

        // St held high: restart straight after the IDLE cycle
        start_op(32'd3, 32'd9);
        finish_op(32'd3, 32'd9, 2);
        chk("held_idle", {62'd0, Load, Busy}, 64'd0);
        start_op(32'd11, 32'd13);
        finish_op(32'd11, 32'd13, 1);

        repeat (6) begin
            a = 32'($urandom);
            b = 32'($urandom);
            repeat ($urandom_range(0, 3)) step();
            start_op(a, b);
            finish_op(a, b, int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
